// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared constants and encodings for the HI/LO multiply/divide controller.
package hilo_mdu_ctrl_pkg;

    localparam int MDU_DATA_W   = 32;
    localparam int MDU_DIV_ITER = 32;

    localparam logic                  WRITE_ENABLE = 1'b1;
    localparam logic [MDU_DATA_W-1:0] ZEROWORD     = '0;

    // Opcode 3'b111 is reserved and decodes like NOP.
    typedef enum logic [2:0] {
        MDU_OP_NOP   = 3'b000,
        MDU_OP_MULT  = 3'b001,
        MDU_OP_MULTU = 3'b010,
        MDU_OP_DIV   = 3'b011,
        MDU_OP_DIVU  = 3'b100,
        MDU_OP_MTHI  = 3'b101,
        MDU_OP_MTLO  = 3'b110
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    // True for the ops that occupy the unit and stall the pipeline.
    function automatic logic is_busy_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_div_radix2_step.sv
// One combinational iteration of a radix-2 restoring divider.
module div_radix2_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] dividend_next,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // Shift in the next dividend bit, trial-subtract, keep the difference if non-negative.
    // rem < divisor always holds, so the extra top bit of diff is a reliable sign.
    always_comb begin
        shifted       = {rem, dividend[DATA_W-1]};
        diff          = shifted - {1'b0, divisor};
        q_bit         = ~diff[DATA_W];
        rem_next      = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        dividend_next = {dividend[DATA_W-2:0], q_bit};
    end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// EX-stage multiply/divide controller sequencing every write into HI/LO.
module hilo_mdu_ctrl
    import hilo_mdu_ctrl_pkg::*;
#(
    parameter int DATA_W   = MDU_DATA_W,
    parameter int DIV_ITER = MDU_DIV_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              hilo_write_en_o,
    output logic [DATA_W-1:0] hi_write_data_o,
    output logic [DATA_W-1:0] lo_write_data_o
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    mdu_state_e        state;
    logic [CNT_W-1:0]  cnt;

    // Multiply operands (also carries the dividend for the divide-by-zero result).
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_signed;
    logic              div_zero;

    // Divider working registers.
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_dq;
    logic [DATA_W-1:0] div_divisor;
    logic              neg_quot;
    logic              neg_rem;

    logic              op_signed;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] dq_next;
    logic              q_bit;
    logic [DATA_W-1:0] quot_fixed;
    logic [DATA_W-1:0] rem_fixed;

    div_radix2_step #(.DATA_W(DATA_W)) u_step (
        .rem           (div_rem),
        .dividend      (div_dq),
        .divisor       (div_divisor),
        .rem_next      (rem_next),
        .dividend_next (dq_next),
        .q_bit         (q_bit)
    );

    // Operand magnitudes for divide and sign-extended multiply operands.
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    always_comb begin
        op_signed  = (op_i == MDU_OP_MULT) || (op_i == MDU_OP_DIV);
        a_mag      = (op_signed && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
        b_mag      = (op_signed && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;
        ext_a      = {{DATA_W{mul_signed & mul_a[DATA_W-1]}}, mul_a};
        ext_b      = {{DATA_W{mul_signed & mul_b[DATA_W-1]}}, mul_b};
        product    = ext_a * ext_b;
        quot_fixed = neg_quot ? -dq_next  : dq_next;
        rem_fixed  = neg_rem  ? -rem_next : rem_next;
    end

    // Stall while an op is being accepted or is in flight; flush releases it at once.
    always_comb begin
        stall_o = ~flush_i &
                  (((state == ST_IDLE) & start_i & is_busy_op(op_i)) |
                   (state == ST_MUL) | (state == ST_DIV));
    end

    // Sequencer FSM with registered write pulse and write data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            mul_a           <= ZEROWORD;
            mul_b           <= ZEROWORD;
            mul_signed      <= 1'b0;
            div_zero        <= 1'b0;
            div_rem         <= ZEROWORD;
            div_dq          <= ZEROWORD;
            div_divisor     <= ZEROWORD;
            neg_quot        <= 1'b0;
            neg_rem         <= 1'b0;
            hilo_write_en_o <= 1'b0;
            hi_write_data_o <= ZEROWORD;
            lo_write_data_o <= ZEROWORD;
        end else begin
            hilo_write_en_o <= 1'b0;
            if (flush_i) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            case (op_i)
                                MDU_OP_MULT, MDU_OP_MULTU: begin
                                    mul_a      <= src_a_i;
                                    mul_b      <= src_b_i;
                                    mul_signed <= op_signed;
                                    div_zero   <= 1'b0;
                                    state      <= ST_MUL;
                                end
                                MDU_OP_DIV, MDU_OP_DIVU: begin
                                    if (src_b_i == ZEROWORD) begin
                                        // Divide by zero reuses the short MUL path.
                                        mul_a    <= src_a_i;
                                        div_zero <= 1'b1;
                                        state    <= ST_MUL;
                                    end else begin
                                        div_rem     <= ZEROWORD;
                                        div_dq      <= a_mag;
                                        div_divisor <= b_mag;
                                        neg_quot    <= op_signed & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
                                        neg_rem     <= op_signed & src_a_i[DATA_W-1];
                                        cnt         <= '0;
                                        state       <= ST_DIV;
                                    end
                                end
                                MDU_OP_MTHI: begin
                                    hilo_write_en_o <= WRITE_ENABLE;
                                    hi_write_data_o <= src_a_i;
                                    lo_write_data_o <= lo_i;
                                end
                                MDU_OP_MTLO: begin
                                    hilo_write_en_o <= WRITE_ENABLE;
                                    hi_write_data_o <= hi_i;
                                    lo_write_data_o <= src_a_i;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        hilo_write_en_o <= WRITE_ENABLE;
                        if (div_zero) begin
                            hi_write_data_o <= mul_a;
                            lo_write_data_o <= {DATA_W{1'b1}};
                        end else begin
                            hi_write_data_o <= product[2*DATA_W-1:DATA_W];
                            lo_write_data_o <= product[DATA_W-1:0];
                        end
                        state <= ST_DONE;
                    end
                    ST_DIV: begin
                        div_rem <= rem_next;
                        div_dq  <= dq_next;
                        cnt     <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            hilo_write_en_o <= WRITE_ENABLE;
                            hi_write_data_o <= rem_fixed;
                            lo_write_data_o <= quot_fixed;
                            cnt             <= '0;
                            state           <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed self-checking bench for the HI/LO multiply/divide controller.
module tb_hilo_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        flush_i;
    logic        stall_o;
    logic        hilo_write_en_o;
    logic [31:0] hi_write_data_o;
    logic [31:0] lo_write_data_o;

    int checks;
    int failures;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    hilo_mdu_ctrl #(.DATA_W(32), .DIV_ITER(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .op_i            (op_i),
        .src_a_i         (src_a_i),
        .src_b_i         (src_b_i),
        .hi_i            (hi_i),
        .lo_i            (lo_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .hilo_write_en_o (hilo_write_en_o),
        .hi_write_data_o (hi_write_data_o),
        .lo_write_data_o (lo_write_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at cycle 0 and follow it cycle by cycle until its write at cycle lat.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic no_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clk);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(negedge clk);
                start_i = 1'b0; op_i = OP_NOP;
            end
            #1;
            chk($sformatf("%s_stall_c%0d", tag, c), {31'd0, stall_o}, {31'd0, (!no_stall && c < lat)});
            chk($sformatf("%s_we_c%0d", tag, c), {31'd0, hilo_write_en_o}, {31'd0, (c == lat)});
        end
        chk({tag, "_hi"}, hi_write_data_o, exp_hi);
        chk({tag, "_lo"}, lo_write_data_o, exp_lo);
        @(negedge clk);
        start_i = 1'b0; op_i = OP_NOP;
        #1;
        chk({tag, "_we_after"}, {31'd0, hilo_write_en_o}, 32'd0);
        chk({tag, "_hi_hold"}, hi_write_data_o, exp_hi);
        chk({tag, "_stall_after"}, {31'd0, stall_o}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; start_i = 1'b0; op_i = OP_NOP; src_a_i = '0; src_b_i = '0;
        hi_i = '0; lo_i = '0; flush_i = 1'b0;

        #3;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_we", {31'd0, hilo_write_en_o}, 32'd0);
        chk("rst_hi", hi_write_data_o, 32'd0);
        chk("rst_lo", lo_write_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // NOP and reserved opcodes do nothing.
        @(negedge clk);
        start_i = 1'b1; op_i = OP_NOP; src_a_i = 32'h1111_1111;
        #1 chk("nop_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        op_i = OP_RSVD;
        #1 chk("rsvd_stall", {31'd0, stall_o}, 32'd0);
        chk("nop_we", {31'd0, hilo_write_en_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; op_i = OP_NOP;
        #1 chk("rsvd_we", {31'd0, hilo_write_en_o}, 32'd0);

        run_op("mult",    OP_MULT,  32'hFFFF_FFFD, 32'd5,         2,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu",   OP_MULTU, 32'hFFFF_FFFF, 32'd2,         2,  1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", OP_DIV,   32'hFFFF_FFF9, 32'd2,         33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",    OP_DIVU,  32'd100,       32'd7,         33, 1'b0, 32'd2,         32'd14);
        run_op("divu_z",  OP_DIVU,  32'h0000_1234, 32'd0,         2,  1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'h0000_0000, 32'h8000_0000);
        run_op("div_nb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);

        lo_i = 32'h0000_0055; hi_i = 32'h0000_0077;
        run_op("mthi",    OP_MTHI,  32'hDEAD_BEEF, 32'd0,         1,  1'b1, 32'hDEAD_BEEF, 32'h0000_0055);
        run_op("mtlo",    OP_MTLO,  32'hCAFE_F00D, 32'd0,         1,  1'b1, 32'h0000_0077, 32'hCAFE_F00D);

        // Flush a divide at cycle 10: no write may ever appear.
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; src_a_i = 32'd100; src_b_i = 32'd7;
        #1 chk("fl_stall_c0", {31'd0, stall_o}, 32'd1);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            start_i = 1'b0; op_i = OP_NOP;
            #1 chk($sformatf("fl_stall_c%0d", c), {31'd0, stall_o}, 32'd1);
        end
        @(negedge clk);
        flush_i = 1'b1;
        #1 chk("fl_stall_c10", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("fl_stall_c11", {31'd0, stall_o}, 32'd0);
        for (int c = 12; c < 38; c++) begin
            @(negedge clk);
            #1 chk($sformatf("fl_we_c%0d", c), {31'd0, hilo_write_en_o | stall_o}, 32'd0);
        end

        // A start coinciding with flush is dropped.
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = OP_MTHI; src_a_i = 32'h1234_5678;
        #1 chk("flst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0; op_i = OP_NOP;
        #1 chk("flst_we", {31'd0, hilo_write_en_o}, 32'd0);
        chk("flst_hi", hi_write_data_o, 32'h0000_0077);

        run_op("multu34", OP_MULTU, 32'd3, 32'd4, 2, 1'b0, 32'd0, 32'd12);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIV; src_a_i = 32'hFFFF_FFF9; src_b_i = 32'd2;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            start_i = 1'b0; op_i = OP_NOP;
        end
        #1 chk("mr_stall_c19", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mr_stall", {31'd0, stall_o}, 32'd0);
        chk("mr_we", {31'd0, hilo_write_en_o}, 32'd0);
        chk("mr_hi", hi_write_data_o, 32'd0);
        chk("mr_lo", lo_write_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1 chk($sformatf("mr_idle_c%0d", c), {31'd0, hilo_write_en_o | stall_o}, 32'd0);
        end

        run_op("mult_post", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
